// File: rtl/fp_pkg.sv
// Shared floating-point adder definitions: default field widths, exponent
// saturation constant and the normalizer state encoding.
package fp_pkg;

  localparam int SIZE_EXP_DEF = 8;
  localparam int SIZE_MAN_DEF = 24;

  localparam logic [SIZE_EXP_DEF-1:0] EXP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/exp_norm_step.sv
// One left-normalization iteration: shift the mantissa by one and decrement
// the exponent, or stop as a denormal once the exponent cannot go lower.
module exp_norm_step #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24
) (
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_MAN-1:0] i_man,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_done,
  output logic                o_underflow
);

  localparam logic [SIZE_EXP-1:0] EXP_ONE = {{(SIZE_EXP-1){1'b0}}, 1'b1};

  logic [SIZE_MAN-1:0] man_shifted;

  always_comb begin
    man_shifted = i_man << 1;
    o_exp       = i_exp - EXP_ONE;
    o_man       = man_shifted;
    o_done      = man_shifted[SIZE_MAN-1];
    o_underflow = 1'b0;
    // Exponent 1 is the smallest normal; further shifting would wrap it.
    if (i_exp <= EXP_ONE) begin
      o_exp       = '0;
      o_man       = i_man;
      o_done      = 1'b1;
      o_underflow = 1'b1;
    end
  end

endmodule

// File: rtl/exp_normalizer.sv
// Post-add normalization: handles carry-out, zero and leading zeros of the
// raw mantissa sum, one left shift per cycle, with valid/ready on both sides.
module exp_normalizer
  import fp_pkg::*;
#(
  parameter int SIZE_EXP = SIZE_EXP_DEF,
  parameter int SIZE_MAN = SIZE_MAN_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [SIZE_EXP-1:0]         i_exp_greater,
  input  logic [SIZE_MAN:0]           i_man_sum,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [SIZE_EXP-1:0]         o_exp,
  output logic [SIZE_MAN-1:0]         o_man,
  output logic [$clog2(SIZE_MAN)-1:0] o_shift_count,
  output logic                        o_zero,
  output logic                        o_overflow,
  output logic                        o_underflow,
  output logic [1:0]                  o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // o_ready and o_valid are decoded purely from the state register.

  localparam int SHW = $clog2(SIZE_MAN);
  localparam logic [SIZE_EXP-1:0] EXP_MAX = {SIZE_EXP{1'b1}};

  state_t              state_q, state_d;
  logic [SIZE_EXP-1:0] exp_q, exp_d;
  logic [SIZE_MAN-1:0] man_q, man_d;
  logic [SHW-1:0]      shift_q, shift_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [SIZE_EXP-1:0] exp_inc;
  logic [SIZE_EXP-1:0] step_exp;
  logic [SIZE_MAN-1:0] step_man;
  logic                step_done;
  logic                step_unf;

  assign exp_inc = i_exp_greater + {{(SIZE_EXP-1){1'b0}}, 1'b1};

  exp_norm_step #(
    .SIZE_EXP (SIZE_EXP),
    .SIZE_MAN (SIZE_MAN)
  ) u_step (
    .i_exp       (exp_q),
    .i_man       (man_q),
    .o_exp       (step_exp),
    .o_man       (step_man),
    .o_done      (step_done),
    .o_underflow (step_unf)
  );

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    man_d   = man_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          shift_d = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = DONE;
          if (i_man_sum == '0) begin
            exp_d  = '0;
            man_d  = '0;
            zero_d = 1'b1;
          end else if (i_man_sum[SIZE_MAN]) begin
            // Carry into the all-ones exponent saturates to infinity.
            if (exp_inc == EXP_MAX || i_exp_greater == EXP_MAX) begin
              exp_d = EXP_MAX;
              man_d = '0;
              ovf_d = 1'b1;
            end else begin
              exp_d = exp_inc;
              man_d = i_man_sum[SIZE_MAN:1];
            end
          end else begin
            exp_d = i_exp_greater;
            man_d = i_man_sum[SIZE_MAN-1:0];
            if (!i_man_sum[SIZE_MAN-1]) begin
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        exp_d = step_exp;
        man_d = step_man;
        if (step_unf) begin
          unf_d = 1'b1;
        end else begin
          shift_d = shift_q + {{(SHW-1){1'b0}}, 1'b1};
        end
        if (step_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      man_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_ready       = (state_q == IDLE);
  assign o_valid       = (state_q == DONE);
  assign o_exp         = exp_q;
  assign o_man         = man_q;
  assign o_shift_count = shift_q;
  assign o_zero        = zero_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;
  assign o_dbg_state   = state_q;

endmodule

// File: doc/exp_normalizer.md
# exp_normalizer

Post-add normalization stage for the floating-point adder: the counterpart of the exponent-difference/alignment front end. Takes the greater exponent and the raw (SIZE_MAN+1)-bit mantissa sum, then renormalizes so the hidden bit sits at the MSB. It handles carry-out by a right shift and leading zeros by iterative one-bit left shifts with exponent decrement, and flags zero, overflow and underflow. Sits between the mantissa adder and the rounding/pack stage, with valid/ready handshakes on both sides.

## Interface
- SIZE_EXP, 8, exponent field width
- SIZE_MAN, 24, mantissa width including hidden bit
- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input transaction valid
- o_ready  out  1  block can accept input; high only in IDLE
- i_exp_greater  in  SIZE_EXP  exponent of the larger operand
- i_man_sum  in  SIZE_MAN+1  mantissa sum; bit [SIZE_MAN] is the carry-out
- o_valid  out  1  result valid; high only in DONE
- i_ready  in  1  downstream accepts the result
- o_exp  out  SIZE_EXP  normalized exponent
- o_man  out  SIZE_MAN  normalized mantissa, hidden bit at [SIZE_MAN-1]
- o_shift_count  out  $clog2(SIZE_MAN)  number of left shifts applied
- o_zero / o_overflow / o_underflow  out  1 each  result flags

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset value: IDLE; every output is 0 except o_ready, which is 1.
- In IDLE, accept when i_valid && o_ready. Capture and classify in priority order:
  - man == 0: exp=0, man=0, o_zero=1, go to DONE.
  - carry bit set: man = sum[SIZE_MAN:1] (LSB truncated), exp+1. If exp+1 == all-ones, also force man=0, set o_overflow=1 and keep exp all-ones. Go to DONE.
  - sum[SIZE_MAN-1] set: already normalized; go to DONE unchanged.
  - otherwise: go to SHIFT.
- Each SHIFT cycle:
  - If exp <= 1: set exp=0, leave man unshifted (denormal), set o_underflow=1, go to DONE.
  - Otherwise: man <<= 1, exp -= 1, shift_count += 1. If the new man MSB is set, go to DONE; otherwise stay in SHIFT.
- In DONE, o_valid=1 and all outputs are held stable until i_ready. On i_valid... handshake completion (o_valid && i_ready), go to IDLE and clear o_valid and the flags; data outputs may hold their last values.
- Arithmetic: exponent ±1 is unsigned, modulo 2^SIZE_EXP. The classification rules above guarantee it never wraps. The flags are mutually exclusive.
- i_valid while o_ready=0 is ignored; upstream must hold its data.
- Reset at any time, including mid-SHIFT or in DONE with stalled i_ready: the in-flight transaction is dropped and all outputs return to their reset values the next cycle.

## Timing
- Accept at edge T.
- Zero, carry and already-normalized cases: o_valid is high from T+1.
- k leading zeros with no underflow: o_valid from T+1+k; maximum k = SIZE_MAN-1.
- Underflow after j completed shifts: o_valid from T+j+2.
- Throughput: one transaction per (latency + 1) cycles at best. The IDLE cycle after handshake completion is mandatory.
- No combinational path from i_valid/i_ready to o_ready/o_valid.

## Structure
- Shared package fp_pkg holds:
  - SIZE_EXP/SIZE_MAN defaults
  - EXP_ALL_ONES constant
  - state typedef enum {IDLE, SHIFT, DONE}
- One combinational sub-module is natural: EXP_norm_step. It takes (exp, man) and returns the next exp, man, done and underflow for one SHIFT iteration. This keeps the FSM to registers plus control.

## Test plan
All scenarios use the default parameters.
- exp=0x80, man=0x0800000 -> o_valid at T+1, exp 0x80, man 0x800000, shift 0, no flags.
- exp=0x80, man=0x1800001 -> T+1, exp 0x81, man 0xC00000 (LSB dropped).
- exp=0x80, man=0x0000100 -> T+16, exp 0x71, man 0x800000, shift 15. Hold i_ready=0 for 5 cycles and check outputs are stable and o_ready=0.
- man=0 with any exp -> T+1, o_zero=1, exp 0, man 0. Also exp=0xFE with carry (man=0x1000000) -> exp 0xFF, man 0, o_overflow=1.
- exp=0x03, man=0x0000010 -> shifts to exp 1/man 0x40, then exp 0, man 0x000040, o_underflow=1, shift 2, o_valid at T+4.
- Assert i_rst during SHIFT (exp=0x80, man=0x0000001, pulse at T+5) -> the next cycle is IDLE with o_valid=0 and o_ready=1. No result emerges, and a fresh transaction completes normally.
